// File: rtl/cpu_pkg.sv
// Shared definitions for the basic processor: default bus geometry, the
// address-width derivation and the wait-state RAM sequencer states.
package cpu_pkg;

   localparam int WORD_W_DEF = 8;
   localparam int OP_W_DEF   = 3;
   localparam int ADDR_W_DEF = WORD_W_DEF - OP_W_DEF;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } ram_state_t;

   // The address field is whatever is left of the word after the opcode.
   function automatic int addr_width(input int word_w, input int op_w);
      return word_w - op_w;
   endfunction

endpackage

// File: rtl/ws_counter.sv
// Loadable 4-bit down-counter that paces the wait states of one RAM access.
// Saturates at zero; 'zero' is decoded from the registered count.
module ws_counter (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/sync_ram_ws.sv
// Windowed data RAM on the shared sysbus with its own MAR/MDR, programmable
// wait states and a ready handshake. Optional out-of-window strobe: SYNC_RAM_ERR_EN.
module sync_ram_ws
   import cpu_pkg::*;
#(
   parameter int WORD_W      = WORD_W_DEF,
   parameter int OP_W        = OP_W_DEF,
   parameter int BASE        = 16,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MDR_bus,
   input  logic              load_MAR,
   input  logic              load_MDR,
   input  logic              CS,
   input  logic              R_NW,
   inout  wire [WORD_W-1:0]  sysbus,
   output logic              ready
`ifdef SYNC_RAM_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int ADDR_W = addr_width(WORD_W, OP_W);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [WORD_W-1:0] mdr_q, mdr_d;
   ram_state_t        state_q, state_d;
   logic              rnw_q, rnw_d;

   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;
   logic              hit;
   logic              miss_req;
   logic              mem_we;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] mem_rdata;

   // Contents survive reset on purpose: only the control path is cleared.
   logic [WORD_W-1:0] mem [0:DEPTH-1];

   ws_counter u_ws_counter (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WS_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   assign hit       = (int'(mar_q) >= BASE) && (int'(mar_q) < (BASE + DEPTH));
   assign idx       = IDX_W'(mar_q - ADDR_W'(BASE));
   assign mem_rdata = mem[idx];

   assign sysbus = (MDR_bus && hit) ? mdr_q : {WORD_W{1'bz}};
   assign ready  = (state_q == IDLE) || ((state_q == WAIT) && cnt_zero);

   always_comb begin
      mar_d    = mar_q;
      mdr_d    = mdr_q;
      state_d  = state_q;
      rnw_d    = rnw_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      mem_we   = 1'b0;
      miss_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_MAR) begin
               mar_d = sysbus[ADDR_W-1:0];
            end else if (load_MDR) begin
               mdr_d = sysbus;
            end else if (CS) begin
               if (!hit) begin
                  miss_req = 1'b1;
               end else if (WAIT_STATES == 0) begin
                  if (R_NW) begin
                     mdr_d = mem_rdata;
                  end else begin
                     mem_we = 1'b1;
                  end
               end else begin
                  state_d  = WAIT;
                  rnw_d    = R_NW;
                  cnt_load = 1'b1;
               end
            end
         end
         WAIT: begin
            // Dropping CS abandons the access before anything is committed.
            if (!CS) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               if (rnw_q) begin
                  mdr_d = mem_rdata;
               end else begin
                  mem_we = 1'b1;
               end
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mar_q   <= '0;
         mdr_q   <= '0;
         state_q <= IDLE;
         rnw_q   <= 1'b0;
      end else begin
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         state_q <= state_d;
         rnw_q   <= rnw_d;
      end
   end

   // A write that coincides with reset is dropped rather than committed.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem[idx] <= mdr_q;
      end
   end

`ifdef SYNC_RAM_ERR_EN
   logic err_q;
   logic err_d;

   assign err_d = miss_req;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_miss;
   assign unused_miss = miss_req;
`endif

endmodule
